// File: rtl/quar_pkg.sv
// Shared definitions for the quarantine-lock controller: state encoding,
// the FSM state type and the default configuration constants.
package quar_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ENTRY   = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ENTRY   = ST_ENTRY,
      CHECK   = ST_CHECK,
      LOCKOUT = ST_LOCKOUT
   } state_t;

   localparam int unsigned DEF_N_DIGITS   = 4;
   localparam int unsigned DEF_DIGIT_W    = 4;
   localparam int unsigned DEF_MAX_TRIES  = 3;
   localparam int unsigned DEF_LOCK_TICKS = 8;

endpackage

// File: rtl/quar_entry_shift.sv
// Digit collection buffer: shifts digits in at the LSB end and keeps a
// saturating count of digits held; clear wins over a shift.
module quar_entry_shift
   import quar_pkg::*;
#(
   parameter int unsigned N_DIGITS = DEF_N_DIGITS,
   parameter int unsigned DIGIT_W  = DEF_DIGIT_W,
   localparam int unsigned CODE_W  = N_DIGITS * DIGIT_W,
   localparam int unsigned CW      = $clog2(N_DIGITS + 1)
) (
   input  logic               slowclock,
   input  logic               reset,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [DIGIT_W-1:0] digit,
   output logic [CODE_W-1:0]  code,
   output logic [CW-1:0]      count
);

   localparam logic [CW-1:0] FULL = CW'(N_DIGITS);

   logic [CODE_W-1:0] code_q, code_d;
   logic [CW-1:0]     count_q, count_d;

   // Once the buffer is full further digits are dropped, so the held code is never disturbed.
   always_comb begin
      code_d  = code_q;
      count_d = count_q;
      if (clear) begin
         code_d  = '0;
         count_d = '0;
      end else if (shift_en && (count_q < FULL)) begin
         code_d  = (code_q << DIGIT_W) | CODE_W'(digit);
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge slowclock or negedge reset) begin
      if (!reset) begin
         code_q  <= '0;
         count_q <= '0;
      end else begin
         code_q  <= code_d;
         count_q <= count_d;
      end
   end

   assign code  = code_q;
   assign count = count_q;

endmodule

// File: rtl/quar_lock_ctrl.sv
// Quarantine-lock controller: collects a code, checks it on pulseC and toggles QUAR.
// Define QUAR_LOCKOUT_EN to enable failed-attempt counting and the timed LOCKOUT state.
module quar_lock_ctrl
   import quar_pkg::*;
#(
   parameter int unsigned N_DIGITS   = DEF_N_DIGITS,
   parameter int unsigned DIGIT_W    = DEF_DIGIT_W,
   parameter int unsigned MAX_TRIES  = DEF_MAX_TRIES,
   parameter int unsigned LOCK_TICKS = DEF_LOCK_TICKS,
   localparam int unsigned CODE_W    = N_DIGITS * DIGIT_W,
   localparam int unsigned CW        = $clog2(N_DIGITS + 1),
   localparam int unsigned TW        = $clog2(MAX_TRIES + 1)
) (
   input  logic               slowclock,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               digit_valid,
   input  logic               pulseC,
   input  logic [CODE_W-1:0]  secret,
   output logic               QUAR,
   output logic               outputFlag,
   output logic               fail,
   output logic               locked,
   output logic [CW-1:0]      entry_count,
   output logic [TW-1:0]      tries_left
);

   localparam logic [CW-1:0] FULL       = CW'(N_DIGITS);
   localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);

   // Zero tries or zero lockout ticks is not a meaningful configuration.
   if ((MAX_TRIES == 0) || (LOCK_TICKS == 0)) begin : g_unsupported_cfg
   end

   state_t            state_q, state_d;
   logic              quar_q, quar_d;
   logic              fail_q, fail_d;
   logic              out_flag_q;
   logic              clear, shift_en, code_match;
   logic [CODE_W-1:0] code;
   logic [CW-1:0]     count;

`ifdef QUAR_LOCKOUT_EN
   localparam int unsigned  LW        = $clog2(LOCK_TICKS + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TICKS - 1);

   logic [TW-1:0] tries_q, tries_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

   quar_entry_shift #(
      .N_DIGITS (N_DIGITS),
      .DIGIT_W  (DIGIT_W)
   ) u_entry (
      .slowclock (slowclock),
      .reset     (reset),
      .clear     (clear),
      .shift_en  (shift_en),
      .digit     (digit_in),
      .code      (code),
      .count     (count)
   );

   assign code_match = (count == FULL) && (code == secret);

   always_comb begin
      state_d  = state_q;
      quar_d   = quar_q;
      fail_d   = 1'b0;
      clear    = 1'b0;
      shift_en = 1'b0;
`ifdef QUAR_LOCKOUT_EN
      tries_d    = tries_q;
      lock_cnt_d = lock_cnt_q;
`endif
      case (state_q)
         IDLE, ENTRY: begin
            if (pulseC) begin
               state_d = CHECK;
            end else if (digit_valid) begin
               shift_en = 1'b1;
               state_d  = ENTRY;
            end
         end
         CHECK: begin
            clear   = 1'b1;
            state_d = IDLE;
            if (code_match) begin
               quar_d = ~quar_q;
`ifdef QUAR_LOCKOUT_EN
               tries_d = TRIES_FULL;
`endif
            end else begin
               fail_d = 1'b1;
`ifdef QUAR_LOCKOUT_EN
               // The last permitted attempt lands at zero rather than wrapping.
               if (tries_q > TW'(1)) begin
                  tries_d = tries_q - TW'(1);
               end else begin
                  tries_d    = '0;
                  lock_cnt_d = '0;
                  state_d    = LOCKOUT;
               end
`endif
            end
         end
`ifdef QUAR_LOCKOUT_EN
         LOCKOUT: begin
            if (lock_cnt_q == LOCK_LAST) begin
               lock_cnt_d = '0;
               tries_d    = TRIES_FULL;
               state_d    = IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q + LW'(1);
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge slowclock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         quar_q     <= 1'b0;
         fail_q     <= 1'b0;
         out_flag_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         quar_q     <= quar_d;
         fail_q     <= fail_d;
         out_flag_q <= 1'b0;
      end
   end

`ifdef QUAR_LOCKOUT_EN
   always_ff @(posedge slowclock or negedge reset) begin
      if (!reset) begin
         tries_q    <= TRIES_FULL;
         lock_cnt_q <= '0;
      end else begin
         tries_q    <= tries_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign locked     = (state_q == LOCKOUT);
   assign tries_left = tries_q;
`else
   assign locked     = 1'b0;
   assign tries_left = TRIES_FULL;
`endif

   assign QUAR        = quar_q;
   assign outputFlag  = out_flag_q;
   assign fail        = fail_q;
   assign entry_count = count;

endmodule
